// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state, op and constant definitions for the iterative multiply/divide unit
package mdu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam logic [63:0] DIVZ_QUO = '1;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/mdu_absval.sv
// mdu_absval: conditional two's-complement negate
module mdu_absval #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply / restoring divide producing HI/LO, one step per cycle
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic             divz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = cnt_width(WIDTH);
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_op, r_sgn, r_sa, r_sb, r_dz;
    logic [WIDTH-1:0]   r_a0, r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_hi, w_lo;
    logic [2*WIDTH-1:0] w_prod, w_step;
    logic [WIDTH:0]     w_sum, w_trial;
    mdu_absval #(.W(WIDTH)) u_abs_a (.i_val(srca), .i_neg(sgn & srca[WIDTH-1]), .o_val(w_mag_a));
    mdu_absval #(.W(WIDTH)) u_abs_b (.i_val(srcb), .i_neg(sgn & srcb[WIDTH-1]), .o_val(w_mag_b));
    mdu_absval #(.W(2*WIDTH)) u_fix_p (.i_val(r_acc), .i_neg(r_sgn & (r_sa ^ r_sb)), .o_val(w_prod));
    mdu_absval #(.W(WIDTH)) u_fix_q (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_sgn & (r_sa ^ r_sb)), .o_val(w_quo));
    mdu_absval #(.W(WIDTH)) u_fix_r (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_sgn & r_sa), .o_val(w_rem));
    // Multiply keeps the multiplier in the low half; divide keeps {rem, quo} in {upper, lower}.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    assign w_step  = (r_op == OP_DIV)
                   ? (w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1})
                   : {w_sum, r_acc[WIDTH-1:1]};
    assign w_hi = r_dz ? r_a0 : (r_op == OP_DIV) ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo = r_dz ? DIVZ_QUO[WIDTH-1:0] : (r_op == OP_DIV) ? w_quo : w_prod[WIDTH-1:0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_sgn   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_a0    <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divz    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_op    <= op;
                    r_sgn   <= sgn;
                    r_sa    <= sgn & srca[WIDTH-1];
                    r_sb    <= sgn & srcb[WIDTH-1];
                    r_dz    <= (op == OP_DIV) && (srcb == '0);
                    r_a0    <= srca;
                    r_b     <= (op == OP_DIV) ? w_mag_b : w_mag_a;
                    r_acc   <= {{WIDTH{1'b0}}, (op == OP_DIV) ? w_mag_a : w_mag_b};
                    r_cnt   <= CW'(WIDTH);
                    busy    <= 1'b1;
                    r_state <= RUN;
                end
                RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= FIX;
                end
                FIX: begin
                    hi      <= w_hi;
                    lo      <= w_lo;
                    divz    <= r_dz;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter against an arithmetic reference model
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        reset, start, op, sgn;
    logic [31:0] srca, srcb;
    logic        busy, done, divz;
    logic [31:0] hi, lo;
    int n_cmp = 0;
    int n_fail = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn),
        .srca(srca), .srcb(srcb), .busy(busy), .done(done), .divz(divz),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: {divz, hi, lo} from plain 64-bit integer arithmetic
    function automatic logic [64:0] model(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y, p, q, r;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        if (o == 1'b0) begin
            p = x * y;
            return {1'b0, p[63:32], p[31:0]};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        q = x / y;
        r = x % y;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic go(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b);
        op = o; sgn = s; srca = a; srcb = b; start = 1'b1;
    endtask

    // Captures at the next edge, then counts edges until done; lat = -1 on timeout.
    // poke > 0 re-asserts start with scrambled operands after that RUN step.
    task automatic wait_done(input int poke, output int lat, output int busy_cyc);
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        busy_cyc = busy ? 1 : 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (done) begin lat = k; break; end
            if (k == poke) begin
                start = 1'b1; op = ~op; sgn = ~sgn; srca = $urandom; srcb = $urandom;
            end
            if (k == poke + 1) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; sgn = 1'b0; srca = '0; srcb = '0;
        #12;
        n_cmp++;
        if ({busy, done, divz, hi, lo} !== 67'd0) begin
            n_fail++; $display("FAIL reset_state: got %b/%b/%b %h %h want all zero", busy, done, divz, hi, lo);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_mul();
        int lat, bc;
        go(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, lat, bc);
        n_cmp++;
        if (lat !== 33) begin n_fail++; $display("FAIL mulu_latency: got %0d want 33", lat); end
        n_cmp++;
        if (bc !== 33) begin n_fail++; $display("FAIL mulu_busy_cycles: got %0d want 33", bc); end
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_fail++; $display("FAIL mulu_result: got %h_%h want fffffffe_00000001", hi, lo); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || {hi, lo} !== 64'hFFFFFFFE_00000001) begin
            n_fail++; $display("FAIL done_pulse_hold: got done=%b %h_%h want done=0 held result", done, hi, lo);
        end
        go(1'b0, 1'b1, 32'hFFFFFFFD, 32'd7);
        wait_done(0, lat, bc);
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB || lat !== 33) begin
            n_fail++; $display("FAIL mul_signed: got %h_%h lat %0d want ffffffff_ffffffeb lat 33", hi, lo, lat);
        end
    endtask

    task automatic test_div();
        int lat, bc;
        go(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(0, lat, bc);
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD || divz !== 1'b0) begin
            n_fail++; $display("FAIL div_signed: got %h_%h divz %b want ffffffff_fffffffd divz 0", hi, lo, divz);
        end
        go(1'b1, 1'b0, 32'd100, 32'd7);
        wait_done(0, lat, bc);
        n_cmp++;
        if ({hi, lo} !== {32'd2, 32'd14} || lat !== 33) begin
            n_fail++; $display("FAIL divu: got %h_%h lat %0d want 00000002_0000000e lat 33", hi, lo, lat);
        end
    endtask

    task automatic test_divz();
        int lat, bc;
        go(1'b1, 1'b1, 32'h12345678, 32'd0);
        wait_done(0, lat, bc);
        n_cmp++;
        if ({divz, hi, lo} !== {1'b1, 32'h12345678, 32'hFFFFFFFF} || lat !== 33) begin
            n_fail++; $display("FAIL div_by_zero: got divz %b %h_%h lat %0d want 1 12345678_ffffffff lat 33", divz, hi, lo, lat);
        end
        go(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(0, lat, bc);
        n_cmp++;
        if ({divz, hi, lo} !== {1'b0, 32'h0, 32'h80000000}) begin
            n_fail++; $display("FAIL div_overflow: got divz %b %h_%h want 0 00000000_80000000", divz, hi, lo);
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        go(1'b0, 1'b0, 32'd123456, 32'd789);
        wait_done(5, lat, bc);
        n_cmp++;
        if ({hi, lo} !== 64'(64'd123456 * 64'd789) || lat !== 33) begin
            n_fail++; $display("FAIL start_while_busy: got %h_%h lat %0d want %h lat 33", hi, lo, lat, 64'd123456 * 64'd789);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        go(1'b0, 1'b0, 32'd1000, 32'd1000);
        wait_done(0, lat, bc);
        n_cmp++;
        if (done !== 1'b1 || lo !== 32'd1000000) begin n_fail++; $display("FAIL b2b_first: got done %b lo %h want 1 000f4240", done, lo); end
        go(1'b1, 1'b0, 32'd1000, 32'd3);
        wait_done(0, lat, bc);
        n_cmp++;
        if ({hi, lo} !== {32'd1, 32'd333} || lat !== 33) begin
            n_fail++; $display("FAIL b2b_second: got %h_%h lat %0d want 00000001_0000014d lat 33", hi, lo, lat);
        end
        go(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, lat, bc);
        n_cmp++;
        if ({hi, lo} !== 64'd1 || lat !== 33) begin
            n_fail++; $display("FAIL b2b_third: got %h_%h lat %0d want 0_1 lat 33", hi, lo, lat);
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        go(1'b1, 1'b0, 32'd7395, 32'd86);
        wait_done(0, lat, bc);
        n_cmp++;
        if ({hi, lo} !== {32'h55, 32'h55}) begin n_fail++; $display("FAIL pre_reset_result: got %h_%h want 55_55", hi, lo); end
        go(1'b0, 1'b0, 32'd9, 32'd9);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            n_fail++; $display("FAIL async_reset: got busy %b done %b %h_%h want all zero", busy, done, hi, lo);
        end
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got busy %b done %b want 0 0", busy, done); end
        go(1'b0, 1'b0, 32'd3, 32'd4);
        wait_done(0, lat, bc);
        n_cmp++;
        if ({hi, lo} !== {32'd0, 32'd12} || lat !== 33) begin
            n_fail++; $display("FAIL post_reset_mul: got %h_%h lat %0d want 0_c lat 33", hi, lo, lat);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic o, s;
        logic [31:0] a, b;
        logic [64:0] exp_v;
        for (int i = 0; i < 60; i++) begin
            o = 1'($urandom); s = 1'($urandom); a = pick(); b = pick();
            exp_v = model(o, s, a, b);
            go(o, s, a, b);
            wait_done(0, lat, bc);
            n_cmp++;
            if ({divz, hi, lo} !== exp_v || lat !== 33) begin
                n_fail++;
                $display("FAIL random_%0d op%b sgn%b %h,%h: got divz %b %h_%h lat %0d want divz %b %h_%h lat 33",
                         i, o, s, a, b, divz, hi, lo, lat, exp_v[64], exp_v[63:32], exp_v[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_divz();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the single-cycle MIPS core. Replaces the combinational MULT/DIV path in the ALU.
- Operands come from the register file read ports (srca/srcb).
- The unit produces the HI/LO pair that the special register file (HI/LO, read by MFHI/MFLO) stores.
- The unit asserts busy so the core's controller can stall the PC while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; also the number of iteration steps.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  1  operation select: 0 = multiply, 1 = divide.
- sgn  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- srca  input  WIDTH  multiplicand / dividend.
- srcb  input  WIDTH  multiplier / divisor.
- busy  output  1  high in RUN and FIX.
- done  output  1  one-cycle pulse when hi/lo carry the new result.
- divz  output  1  registered with done; high if the completed op was a divide by zero.
- hi  output  WIDTH  product upper half / remainder; holds value until the next done.
- lo  output  WIDTH  product lower half / quotient; holds value until the next done.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE; busy = done = divz = 0; hi = lo = 0; step counter = 0.
  - Any in-flight operation is discarded.
- State machine:
  - IDLE: at an edge with start = 1, capture op, sgn, and the signs of srca/srcb (MSB and sgn).
    - Load |srca| and |srcb| (two's-complement magnitude if signed and negative, else raw).
    - Record divz = op & (srcb == 0).
    - counter = WIDTH; go to RUN.
  - RUN: one step per edge; counter decrements; after the edge that brings counter to 0, go to FIX.
    - Multiply step: radix-2 shift-add on a 2*WIDTH accumulator. If the accumulator LSB is 1, add the multiplicand to the upper half (WIDTH+1-bit sum), then shift right 1.
    - Divide step: restoring. Shift {rem, quo} left 1. Trial-subtract the divisor from rem (WIDTH+1 bits). If non-negative, keep the difference and set the quo LSB to 1.
  - FIX: single edge. Apply sign correction, load hi/lo, set done = 1 and divz, go to IDLE.
- Sign correction:
  - Multiply: negate the 2*WIDTH product if sgn & (sa ^ sb).
  - Divide: negate the quotient if sgn & (sa ^ sb); negate the remainder if sgn & sa (remainder takes the dividend's sign).
- Divide by zero:
  - Iterations run normally (uniform latency).
  - FIX forces hi = original srca and lo = all ones; divz = 1.
- Signed overflow (most-negative / -1):
  - lo = 0x80000000 (WIDTH-scaled), hi = 0.
  - No trap, divz = 0.
- Latency: let E0 be the start-capturing edge.
  - Steps occur at edges E1..E(WIDTH).
  - FIX occurs at edge E(WIDTH+1); done is high for exactly the following cycle.
  - busy is high from after E0 until E(WIDTH+1).
  - For WIDTH = 32: 33 edges from start capture to result.
- done and busy:
  - start while busy: ignored, with no side effects on operands or state.
  - start in the cycle done = 1: accepted (state is IDLE).
  - done is cleared at the next edge; hi/lo hold their values.
- Operand stability: srca/srcb/op/sgn are needed only at E0 and may change afterwards.

Decomposition:
- Shared package mdu_pkg:
  - state encoding: IDLE, RUN, FIX.
  - op constants: OP_MUL = 0, OP_DIV = 1.
  - divide-by-zero quotient constant (all ones).
  - counter width $clog2(WIDTH+1).
- Sub-module mdu_absval: conditional two's-complement negate (input value, negate flag → output). Instantiated for the operand magnitudes and for the result fix-up.
- FSM and datapath stay in mdu_iter.

Test Plan:
- Unsigned multiply, sgn = 0, op = 0, srca = srcb = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. done exactly 33 edges after start capture; busy high for 33 cycles.
- Signed multiply, srca = 0xFFFFFFFD (-3), srcb = 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB (-21).
- Signed divide, srca = 0xFFFFFFF9 (-7), srcb = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Unsigned divide 100 / 7 → lo = 14, hi = 2.
- Divide by zero, srca = 0x12345678, srcb = 0 → hi = 0x12345678, lo = 0xFFFFFFFF, divz = 1 with done. Then signed 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, divz = 0.
- Pulse start again at RUN step 5 with different operands → ignored; the original result is returned. Start asserted in the done cycle → new op accepted; back-to-back results are each 33 edges apart.
- Assert reset asynchronously (off-edge) at RUN step 10 after a prior result hi = lo = 0x55 → busy, done, hi, lo go to 0 immediately. After release, a fresh 3 × 4 (op = 0) yields lo = 12, hi = 0.
